steer_en_fsm: RTL and testbench

//  Rider-presence and steering-enable controller. Sits between the A2D load-cell

---
 rtl/steer_en_fsm_if.sv | 19 +
 rtl/steer_en_fsm.sv | 105 ++++++++++
 tb/tb_steer_en_fsm.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/steer_en_fsm_if.sv
// Load-sample strobe and enable outputs shared by the A2D sampler, steer_en_fsm
// and the balance/steer controller.
interface steer_en_fsm_if;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    modport master (
        output ld_vld, lft_ld, rght_ld,
        input  en_steer, rider_off
    );

    modport slave (
        input  ld_vld, lft_ld, rght_ld,
        output en_steer, rider_off
    );
endinterface

// File: rtl/steer_en_fsm.sv
// Rider-presence and steering-enable controller: enables steering after the rider
// has stood balanced for a full timer period, drops it on step-off or heavy lean.
module steer_en_fsm #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter bit          FAST_SIM         = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    steer_en_fsm_if.slave bus
);

    localparam logic [25:0] TMR_TC = FAST_SIM ? 26'h000_7FFF : 26'h3FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEER
    } state_e;

    state_e      state_q,     state_d;
    logic [25:0] tmr_q,       tmr_d;
    logic [11:0] lft_q,       lft_d;
    logic [11:0] rght_q,      rght_d;
    logic        en_steer_q,  en_steer_d;
    logic        rider_off_q, rider_off_d;

    logic [12:0] sum;
    logic [11:0] diff;
    logic [16:0] sum_x15;
    logic        present;
    logic        bal;
    logic        lopsided;
    logic        tmr_full;
    logic        tmr_clr;

    // Widened arithmetic keeps every comparison exact for full-scale loads.
    assign sum      = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff     = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    assign sum_x15  = {sum, 4'b0000} - {4'b0000, sum};
    assign present  = sum >= {1'b0, MIN_RIDER_WEIGHT};
    assign bal      = {diff, 2'b00} < {1'b0, sum};
    assign lopsided = {1'b0, diff, 4'b0000} > sum_x15;
    assign tmr_full = tmr_q == TMR_TC;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        tmr_clr = 1'b0;
        lft_d   = bus.ld_vld ? bus.lft_ld  : lft_q;
        rght_d  = bus.ld_vld ? bus.rght_ld : rght_q;

        unique case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (present) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!present)      state_d = ST_IDLE;
                else if (!bal)     tmr_clr = 1'b1;
                else if (tmr_full) state_d = ST_STEER;
            end
            ST_STEER: begin
                // Balance is deliberately not re-checked here: only a heavy lean leaves.
                if (!present) begin
                    state_d = ST_IDLE;
                end else if (lopsided) begin
                    state_d = ST_WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmr_clr)       tmr_d = '0;
        else if (tmr_full) tmr_d = tmr_q;
        else               tmr_d = tmr_q + 26'd1;

        en_steer_d  = state_d == ST_STEER;
        rider_off_d = !present;
    end

    always_ff @(posedge clk) begin
        // NOTE: all state is cleared by reset, so a mid-operation reset leaves nothing behind.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            lft_q       <= '0;
            rght_q      <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    assign bus.en_steer  = en_steer_q;
    assign bus.rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en_fsm.sv
// Self-checking bench for steer_en_fsm: directed vectors and timing sequences plus
// randomized samples, all scored against a rider-streak reference model.
module tb_steer_en_fsm;

    localparam int unsigned TC      = (1 << 15) - 1;
    localparam int unsigned MIN_WT  = 'h200;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_r_n;

    always #5 clk = ~clk;

    steer_en_fsm_if bus ();
    steer_en_fsm_if bus_r ();

    // Second instance follows the same load stream but has its own reset.
    assign bus_r.ld_vld  = bus.ld_vld;
    assign bus_r.lft_ld  = bus.lft_ld;
    assign bus_r.rght_ld = bus.rght_ld;

    steer_en_fsm #(.MIN_RIDER_WEIGHT(12'h200), .FAST_SIM(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    steer_en_fsm #(.MIN_RIDER_WEIGHT(12'h200), .FAST_SIM(1'b1)) dut_r (
        .clk   (clk),
        .rst_n (rst_r_n),
        .bus   (bus_r)
    );

    // Reference model: steering turns on after TC+1 consecutive balanced cycles
    // of a rider that was already present the cycle before counting started.
    typedef struct {
        int unsigned lft;
        int unsigned rght;
        bit          on;
        bit          armed;
        int unsigned streak;
        bit          off;
    } mdl_t;

    mdl_t m [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.lft = 0; s.rght = 0; s.on = 1'b0; s.armed = 1'b0; s.streak = 0; s.off = 1'b1;
        return s;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s, input logic ok, input logic vld,
                                      input logic [11:0] l, input logic [11:0] r);
        mdl_t        n;
        int unsigned sum;
        int unsigned diff;
        bit          present;
        bit          bal;
        bit          lop;
        n = s;
        if (!ok) return mdl_reset();
        sum     = s.lft + s.rght;
        diff    = (s.lft > s.rght) ? s.lft - s.rght : s.rght - s.lft;
        present = sum >= MIN_WT;
        bal     = 4 * diff < sum;
        lop     = 16 * diff > 15 * sum;
        n.off   = !present;
        if (vld) begin
            n.lft  = {20'd0, l};
            n.rght = {20'd0, r};
        end
        if (!present) begin
            n.on = 1'b0; n.armed = 1'b0; n.streak = 0;
        end else if (s.on) begin
            if (lop) begin
                n.on = 1'b0; n.armed = 1'b1; n.streak = 0;
            end
        end else if (!s.armed) begin
            n.armed = 1'b1;
        end else if (!bal) begin
            n.streak = 0;
        end else begin
            n.streak = s.streak + 1;
            if (n.streak == TC + 1) begin
                n.on = 1'b1; n.streak = 0;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [11:0] l, input logic [11:0] r);
        bus.ld_vld  = vld;
        bus.lft_ld  = l;
        bus.rght_ld = r;
    endtask

    task automatic tick(input bit chk);
        @(posedge clk);
        m[0] = mdl_next(m[0], rst_n,   bus.ld_vld, bus.lft_ld, bus.rght_ld);
        m[1] = mdl_next(m[1], rst_r_n, bus.ld_vld, bus.lft_ld, bus.rght_ld);
        @(negedge clk);
        if (chk) begin
            check("mdl_en",    bus.en_steer,    m[0].on);
            check("mdl_off",   bus.rider_off,   m[0].off);
            check("mdl_r_en",  bus_r.en_steer,  m[1].on);
            check("mdl_r_off", bus_r.rider_off, m[1].off);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick((i % 4096) == 0 || i == n - 1);
    endtask

    // One-cycle sample strobe; loads stay on the pins afterwards with ld_vld low.
    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        drive(1'b1, l, r);
        tick(1'b1);
        drive(1'b0, l, r);
    endtask

    typedef struct {
        logic        vld;
        logic [11:0] lft;
        logic [11:0] rght;
        logic        exp_off;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [11:0] a, b;

        vecs[0] = '{1'b1, 12'h0FF, 12'h100, 1'b1};   // sum 0x1FF
        vecs[1] = '{1'b1, 12'h100, 12'h100, 1'b0};   // sum == minimum
        vecs[2] = '{1'b1, 12'h000, 12'h000, 1'b1};
        vecs[3] = '{1'b1, 12'h201, 12'h000, 1'b0};
        vecs[4] = '{1'b1, 12'h000, 12'h1FF, 1'b1};
        vecs[5] = '{1'b1, 12'hFFF, 12'hFFF, 1'b0};   // full scale, no overflow
        vecs[6] = '{1'b0, 12'h000, 12'h000, 1'b0};   // not strobed: capture holds
        vecs[7] = '{1'b1, 12'h0F0, 12'h100, 1'b1};

        m[0] = mdl_reset();
        m[1] = mdl_reset();

        // Reset held three clocks with a heavy rider strobed on the pins.
        rst_n = 1'b0; rst_r_n = 1'b0;
        drive(1'b1, 12'h300, 12'h300);
        tick(1'b0); tick(1'b0); tick(1'b1);
        check("rst_en",  bus.en_steer,  1'b0);
        check("rst_off", bus.rider_off, 1'b1);
        rst_n = 1'b1; rst_r_n = 1'b1;
        drive(1'b0, 12'h300, 12'h300);
        tick(1'b1);
        check("rel_off_hold", bus.rider_off, 1'b1);
        strobe(12'h300, 12'h300);
        check("rel_off_lat1", bus.rider_off, 1'b1);
        tick(1'b1);
        check("rel_off_lat2", bus.rider_off, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].lft, vecs[i].rght);
            tick(1'b1);
            drive(1'b0, vecs[i].lft, vecs[i].rght);
            tick(1'b1);
            check($sformatf("vec%0d_off", i), bus.rider_off, vecs[i].exp_off);
            check($sformatf("vec%0d_en", i),  bus.en_steer,  1'b0);
        end

        // Under weight, sampled every clock.
        drive(1'b1, 12'h0F0, 12'h100);
        for (int i = 0; i < 256; i++) tick(1'b1);
        check("uw_off", bus.rider_off, 1'b1);
        check("uw_en",  bus.en_steer,  1'b0);

        // Enable timing: WAIT entry is the edge after the capture edge.
        strobe(12'h150, 12'h100);
        tick(1'b1);
        check("en_wait_off", bus.rider_off, 1'b0);
        run(TC - 1);
        tick(1'b1);
        check("en_early", bus.en_steer, 1'b0);
        tick(1'b1);
        check("en_rise", bus.en_steer, 1'b1);

        // One-clock reset of the second instance while steering.
        rst_r_n = 1'b0;
        tick(1'b1);
        check("rst_mid_en",   bus_r.en_steer,  1'b0);
        check("rst_mid_off",  bus_r.rider_off, 1'b1);
        check("rst_other_en", bus.en_steer,    1'b1);
        rst_r_n = 1'b1;
        tick(1'b1);
        check("rst_mid_cap", bus_r.rider_off, 1'b1);

        // 60 % lean and the exact 15/16 boundary both keep steering.
        strobe(12'h400, 12'h100);
        tick(1'b1);
        check("lean60_en", bus.en_steer, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1);
        strobe(12'h3E0, 12'h020);
        tick(1'b1);
        check("lop_edge_en", bus.en_steer, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1);

        // Lopsided sample drops steering one clock after it is captured.
        strobe(12'h400, 12'h010);
        check("lop_lat_en", bus.en_steer, 1'b1);
        tick(1'b1);
        check("lop_drop_en",  bus.en_steer,  1'b0);
        check("lop_drop_off", bus.rider_off, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1);

        // Timer restart: diff*4 == sum mid-count counts as unbalanced.
        strobe(12'h150, 12'h100);
        run(8192);
        strobe(12'h280, 12'h180);
        strobe(12'h150, 12'h100);
        run(TC - 1);
        tick(1'b1);
        check("restart_early", bus.en_steer, 1'b0);
        tick(1'b1);
        check("restart_rise", bus.en_steer, 1'b1);

        // Step-off while steering.
        strobe(12'h000, 12'h000);
        check("off_lat_en", bus.en_steer, 1'b1);
        tick(1'b1);
        check("off_en",  bus.en_steer,  1'b0);
        check("off_off", bus.rider_off, 1'b1);

        // Randomized samples and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 12'($urandom_range(0, 4095));
                    b = 12'($urandom_range(0, 4095));
                end
                1: begin
                    a = 12'($urandom_range(0, 'h1FF));
                    b = 12'h1FF - a + 12'($urandom_range(0, 2));
                end
                2: begin
                    a = 12'($urandom_range('h200, 'h600));
                    b = a - 12'($urandom_range(0, 'h100));
                end
                default: begin
                    a = 12'($urandom_range('h300, 'hFFF));
                    b = 12'($urandom_range(0, 32));
                end
            endcase
            if ($urandom_range(0, 1) == 1) drive($urandom_range(0, 2) == 0, b, a);
            else                           drive($urandom_range(0, 2) == 0, a, b);
            rst_n   = $urandom_range(0, 499) != 0;
            rst_r_n = $urandom_range(0, 499) != 0;
            tick(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
